// File: rtl/l2_trigger_scheduler.sv
// Turns per-phi L2 trigger levels into single req/ack trigger requests.
// Simultaneous phi sectors are served round-robin; a post-ack holdoff is enforced and lost edges are counted.
module l2_trigger_scheduler #(
    parameter int unsigned NUM_PHI   = 2,
    parameter int unsigned PHI_W     = 1,
    parameter int unsigned HOLDOFF_W = 8,
    parameter int unsigned DROP_W    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 enable_i,
    input  logic [NUM_PHI-1:0]   l2_i,
    input  logic [HOLDOFF_W-1:0] holdoff_i,
    input  logic                 trig_ack_i,
    input  logic                 clr_drop_i,
    output logic                 trig_req_o,
    output logic [PHI_W-1:0]     trig_phi_o,
    output logic                 busy_o,
    output logic [DROP_W-1:0]    drop_count_o
);

    typedef enum logic [1:0] {StIdle, StReq, StHoldoff} state_e;

    state_e                 state_q, state_d;
    logic [NUM_PHI-1:0]     l2_q;
    logic [NUM_PHI-1:0]     pending_q, pending_d;
    logic [HOLDOFF_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [PHI_W-1:0]       last_grant_q, last_grant_d;
    logic                   req_q, req_d;
    logic [PHI_W-1:0]       phi_q, phi_d;
    logic                   busy_q, busy_d;
    logic [DROP_W-1:0]      drop_q, drop_d;

    logic [NUM_PHI-1:0]     edge_det;
    logic [DROP_W-1:0]      drop_inc;
    logic [DROP_W:0]        drop_sum;
    logic                   grant_vld;
    logic [PHI_W-1:0]       grant;
    int unsigned            idx;

    assign edge_det = l2_i & ~l2_q;

    // Round-robin search starting just after the last granted sector.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        idx       = 0;
        for (int unsigned i = 1; i <= NUM_PHI; i++) begin
            idx = (32'(last_grant_q) + i) % NUM_PHI;
            if (!grant_vld && pending_q[idx[PHI_W-1:0]]) begin
                grant_vld = 1'b1;
                grant     = idx[PHI_W-1:0];
            end
        end
    end

    always_comb begin
        pending_d    = pending_q;
        drop_inc     = '0;
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        last_grant_d = last_grant_q;
        req_d        = req_q;
        phi_d        = phi_q;

        if (enable_i) begin
            for (int unsigned k = 0; k < NUM_PHI; k++) begin
                if (edge_det[k]) begin
                    if (state_q != StHoldoff && !pending_q[k]) begin
                        pending_d[k] = 1'b1;
                    end else begin
                        drop_inc = drop_inc + DROP_W'(1);
                    end
                end
            end
        end else begin
            pending_d = '0;
        end

        unique case (state_q)
            StIdle: begin
                if (grant_vld) begin
                    state_d      = StReq;
                    req_d        = 1'b1;
                    phi_d        = grant;
                    last_grant_d = grant;
                end
            end
            StReq: begin
                if (trig_ack_i) begin
                    pending_d[phi_q] = 1'b0;
                    req_d            = 1'b0;
                    if (holdoff_i == '0) begin
                        state_d = StIdle;
                    end else begin
                        hold_cnt_d = holdoff_i;
                        state_d    = StHoldoff;
                    end
                end
            end
            StHoldoff: begin
                hold_cnt_d = hold_cnt_q - HOLDOFF_W'(1);
                if (hold_cnt_q == HOLDOFF_W'(1)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);

        // Carry out of the widened sum means the counter would wrap: clamp instead.
        drop_sum = {1'b0, drop_q} + {1'b0, drop_inc};
        if (clr_drop_i) begin
            drop_d = '0;
        end else if (drop_sum[DROP_W]) begin
            drop_d = '1;
        end else begin
            drop_d = drop_sum[DROP_W-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= StIdle;
            l2_q         <= '0;
            pending_q    <= '0;
            hold_cnt_q   <= '0;
            last_grant_q <= PHI_W'(NUM_PHI - 1);
            req_q        <= 1'b0;
            phi_q        <= '0;
            busy_q       <= 1'b0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            l2_q         <= l2_i;
            pending_q    <= pending_d;
            hold_cnt_q   <= hold_cnt_d;
            last_grant_q <= last_grant_d;
            req_q        <= req_d;
            phi_q        <= phi_d;
            busy_q       <= busy_d;
            drop_q       <= drop_d;
        end
    end

    assign trig_req_o   = req_q;
    assign trig_phi_o   = phi_q;
    assign busy_o       = busy_q;
    assign drop_count_o = drop_q;

endmodule

// File: doc/l2_trigger_scheduler.md
Name: l2_trigger_scheduler

Overview:
- Sits downstream of the dual-phi L1/L2 trigger block and upstream of the trigger/readout interface.
- Converts per-phi L2 trigger levels into single-event requests using a req/ack handshake.
- Arbitrates simultaneous phi sectors round-robin, enforces a programmable post-ack holdoff (deadtime), and counts lost triggers in a saturating counter.

Parameters:
NUM_PHI, 2, number of phi-sector L2 inputs
PHI_W, 1, width of phi index (ceil(log2(NUM_PHI)), minimum 1)
HOLDOFF_W, 8, width of holdoff length in clk_i cycles
DROP_W, 16, width of dropped-trigger counter

Ports:
clk_i  input  1  trigger clock (250 MHz domain); single clock for the whole block
rst_n_i  input  1  reset; asynchronous, active-low
enable_i  input  1  accept new L2 triggers when high
l2_i  input  NUM_PHI  per-phi L2 trigger level (multi-cycle oneshot, synchronous to clk_i)
holdoff_i  input  HOLDOFF_W  deadtime in cycles after each ack; sampled at ack
trig_ack_i  input  1  downstream acknowledge of trig_req_o
clr_drop_i  input  1  synchronous clear of drop_count_o
trig_req_o  output  1  trigger request, held until acked
trig_phi_o  output  PHI_W  phi index of current request; valid while trig_req_o is high
busy_o  output  1  high whenever FSM is not IDLE
drop_count_o  output  DROP_W  saturating count of lost trigger edges

Behaviour:
- Reset (rst_n_i low, async): FSM=IDLE, l2_q=0, pending=0, hold_cnt=0, last_grant=NUM_PHI-1, trig_req_o=0, trig_phi_o=0, busy_o=0, drop_count_o=0. Reset asserted mid-REQ or mid-HOLDOFF aborts immediately with no ack required.
- Edge detect: l2_q<=l2_i each cycle; edge[k]=l2_i[k]&~l2_q[k]. A held-high level produces exactly one edge.
- Pending/drop rules per k, evaluated at each clock edge where enable_i=1 and edge[k]=1:
  - If FSM!=HOLDOFF and pending[k]=0: set pending[k].
  - Else: drop_count_o+1, saturating at all-ones.
- enable_i=0: edges ignored and not counted; pending cleared. An outstanding REQ is not aborted and completes normally.
- FSM states and transitions:
  - IDLE: if any pending, go to REQ. Grant the first pending index searching upward from last_grant+1 (mod NUM_PHI). Register trig_phi_o=grant, last_grant=grant, trig_req_o=1.
  - REQ: trig_req_o held high and trig_phi_o stable until trig_ack_i=1 is sampled. On ack:
    - clear pending[trig_phi_o]; trig_req_o=0;
    - if holdoff_i==0, go to IDLE; else load hold_cnt=holdoff_i and go to HOLDOFF.
    - An edge on the granted phi in the ack cycle counts as a drop, because pending was still set.
  - HOLDOFF: hold_cnt decrements each cycle. When hold_cnt==1, go to IDLE. Total HOLDOFF residency is exactly holdoff_i cycles. Every edge in HOLDOFF is dropped and counted.
- trig_ack_i sampled outside REQ is ignored.
- Latency: edge sampled at clock N sets pending at N; trig_req_o is high after clock N+1 (2-cycle edge-to-request).
- Back-to-back: a second phi that became pending during REQ is granted on the first IDLE cycle after HOLDOFF.
- busy_o is a registered decode of FSM!=IDLE.
- clr_drop_i zeroes drop_count_o next cycle and has priority over a simultaneous increment.
- Simultaneous drops on multiple phi in one cycle add the number of dropped edges, saturating.

Test Plan:
- Reset, enable_i=1, holdoff_i=4; pulse l2_i=01 for 3 cycles → trig_req_o rises 2 cycles after the edge with trig_phi_o=0; ack 3 cycles later → req falls, busy_o high for exactly 4 more cycles, drop_count_o=0.
- l2_i=11 on the same cycle → first grant phi0, ack, holdoff 4, then second grant phi1. Repeat with 11 → phi0 granted first again (round-robin from last_grant=1).
- Edge on phi1 during HOLDOFF, plus a second phi0 edge while phi0 is pending in REQ → drop_count_o=2, and no extra request is issued.
- holdoff_i=0: ack → FSM in IDLE the next cycle; a pending phi1 produces trig_req_o on the following cycle. Also assert rst_n_i low mid-REQ → all outputs 0 asynchronously.
- enable_i=0 with l2_i edges → no requests, drop_count_o unchanged. Drop enable_i during REQ → request persists until ack, and pending for the other phi is cleared.
- Force drop counter to 0xFFFE and drop 3 edges → drop_count_o saturates at 0xFFFF. clr_drop_i together with a drop in the same cycle → 0.
